// File: rtl/ahb_burst_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_burst_sub : AHB-Lite RAM subordinate with NONSEQ wait states and      |
// |                 burst-beat tracking. Optional macro: AHB_BURST_SUB_ERR_EN |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module ahb_burst_sub #(
  parameter int XLEN      = 64,
  parameter int PA_BITS   = 32,
  parameter int DEPTH     = 1024,
  parameter int NSEQ_WAIT = 2
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [XLEN-1:0]     HWDATA,
  input  logic [XLEN/8-1:0]   HWSTRB,
  input  logic                HREADY,
  output logic [XLEN-1:0]     HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic                BurstDone
);
  localparam int STRB_W   = XLEN / 8;
  localparam int WORD_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (NSEQ_WAIT > 0) ? 4'(NSEQ_WAIT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
`ifdef AHB_BURST_SUB_ERR_EN
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4,
`endif
    S_DATA = 3'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        beat_q, beat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic [2:0]        burst_q, burst_d;
  logic              hreadyout_q, hreadyout_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              slot_open, accept, nonseq, beat_done, wr_en, unused_bits;
  logic [3:0]        thresh;

`ifdef AHB_BURST_SUB_ERR_EN
  logic              addr_err, hresp_q, hresp_d;
  assign slot_open   = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign beat_done   = HREADY && ((state_q == S_DATA) || (state_q == S_ERR2));
  // Any address bit above the index field means the word lies beyond DEPTH.
  assign addr_err    = (|HADDR[PA_BITS-1:WORD_LSB+IDX_W]) || (HSIZE > 3'(WORD_LSB));
  assign hreadyout_d = (state_d != S_WAIT) && (state_d != S_ERR1);
  assign hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  assign HRESP       = hresp_q;
  assign unused_bits = ^HADDR[WORD_LSB-1:0];
`else
  assign slot_open   = (state_q == S_IDLE) || (state_q == S_DATA);
  assign beat_done   = HREADY && (state_q == S_DATA);
  assign hreadyout_d = (state_d != S_WAIT);
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HSIZE, HADDR[PA_BITS-1:WORD_LSB+IDX_W], HADDR[WORD_LSB-1:0]};
`endif

  assign accept = HSEL && HTRANS[1] && HREADY && slot_open;
  assign nonseq = !HTRANS[0];
  assign thresh = (burst_q == 3'b000) ? 4'd0 : 4'((5'd2 << burst_q[2:1]) - 5'd1);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    write_d = write_q;
    burst_d = burst_q;
    if (beat_done) beat_d = beat_q + 4'd1;
    case (state_q)
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_DATA;
        else                     wait_d  = wait_q + 4'd1;
      end
`ifdef AHB_BURST_SUB_ERR_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        if (accept) begin
          idx_d   = HADDR[WORD_LSB +: IDX_W];
          write_d = HWRITE;
          burst_d = HBURST;
          // A NONSEQ restarts beat tracking, silently dropping any unfinished burst.
          if (nonseq) beat_d = '0;
`ifdef AHB_BURST_SUB_ERR_EN
          if (addr_err) state_d = S_ERR1;
          else
`endif
          if (nonseq && (NSEQ_WAIT > 0)) begin
            state_d = S_WAIT;
            wait_d  = '0;
          end else begin
            state_d = S_DATA;
          end
        end else if (beat_done || !slot_open) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      burst_q     <= 3'b000;
      hreadyout_q <= 1'b1;
`ifdef AHB_BURST_SUB_ERR_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      burst_q     <= burst_d;
      hreadyout_q <= hreadyout_d;
`ifdef AHB_BURST_SUB_ERR_EN
      hresp_q     <= hresp_d;
`endif
    end
  end

  // Write only when the data phase really completes; a stalled bus or reset drops it.
  assign wr_en = (state_q == S_DATA) && HREADY && write_q && !HRESET;

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (HWSTRB[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = (state_q == S_DATA) ? mem_q[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign BurstDone = beat_done && (beat_q == thresh) && !HRESET;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_sub.sv
`default_nettype none
// Bench for ahb_burst_sub: bus driver tasks push expectations, a negedge
// monitor pops them as data phases complete.
module tb_ahb_burst_sub;
  localparam int DEPTH     = 1024;
  localparam int NSEQ_WAIT = 2;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd3;
  logic [2:0]  HBURST = 3'b000;
  logic [63:0] HWDATA = '0;
  logic [7:0]  HWSTRB = '0;
  logic        HREADY;
  logic [63:0] HRDATA;
  logic        HREADYOUT, HRESP, BurstDone;
  logic        stall = 1'b0;

  assign HREADY = HREADYOUT & ~stall;

  ahb_burst_sub #(.XLEN(64), .PA_BITS(32), .DEPTH(DEPTH), .NSEQ_WAIT(NSEQ_WAIT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .BurstDone(BurstDone)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          rd;
    logic [63:0] data;
    bit          done;
    int          waits;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        it;
  logic [63:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;
  bit          dp_valid = 1'b0;
  int          waits = 0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      sb.delete();
      dp_valid = 1'b0;
      waits = 0;
    end else begin
      if (dp_valid && !HREADYOUT) begin
        waits++;
        if (sb.size() > 0) begin
          checks++;
          if (HRESP !== sb[0].err) begin
            errors++;
            $display("FAIL wait_hresp got %b want %b", HRESP, sb[0].err);
          end
        end
      end else if (dp_valid && HREADY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got completion want none");
        end else begin
          it = sb.pop_front();
          if (waits !== it.waits || BurstDone !== it.done || HRESP !== it.err ||
              (it.rd && HRDATA !== it.data)) begin
            errors++;
            $display("FAIL beat got waits=%0d done=%b resp=%b data=%h want waits=%0d done=%b resp=%b data=%h",
                     waits, BurstDone, HRESP, HRDATA, it.waits, it.done, it.err, it.data);
          end
        end
        waits = 0;
      end else begin
        checks++;
        if (BurstDone !== 1'b0 || (!dp_valid && (HRDATA !== 64'd0 || HREADYOUT !== 1'b1))) begin
          errors++;
          $display("FAIL idle_outputs got done=%b data=%h rdy=%b want done=0 data=0 rdy=1",
                   BurstDone, HRDATA, HREADYOUT);
        end
      end
      if (HREADY) dp_valid = HSEL && HTRANS[1];
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge HCLK);
    while (!HREADY) begin
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout got HREADY=0 want 1 within 40 cycles");
        break;
      end
      @(negedge HCLK);
    end
  endtask

  task automatic beat(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                      input logic [2:0] burst, input logic [63:0] wdata, input logic [7:0] strb,
                      input bit last, input int stall_cyc);
    exp_t e;
    int   idx = int'(addr[3 +: 10]);
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = trans; HBURST = burst; HSIZE = 3'd3;
`ifdef AHB_BURST_SUB_ERR_EN
    e.err = (|addr[31:13]);
`else
    e.err = 1'b0;
`endif
    e.rd    = !wr;
    e.done  = last;
    e.waits = e.err ? 1 : ((trans == T_NONSEQ) ? NSEQ_WAIT : 0);
    if (wr && !e.err) begin
      for (int b = 0; b < 8; b++) if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    e.data = (wr || e.err) ? 64'd0 : model[idx];
    sb.push_back(e);
    if (stall_cyc > 0) begin
      stall = 1'b1;
      repeat (stall_cyc) @(posedge HCLK);
      #1 stall = 1'b0;
    end
    wait_ready();
    @(posedge HCLK); #1;
    HWDATA = wdata;
    HWSTRB = strb;
  endtask

  task automatic idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    wait_ready();
    @(posedge HCLK); #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'd0 || BurstDone !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got rdy=%b resp=%b data=%h done=%b want 1 0 0 0",
                 HREADYOUT, HRESP, HRDATA, BurstDone);
      end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_single();
    beat(32'h40, 1'b1, T_NONSEQ, B_SINGLE, 64'h1122334455667788, 8'hFF, 1'b1, 0);
    idle();
    beat(32'h40, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    idle();
    check_drained("single");
  endtask

  task automatic test_incr4_read();
    for (int i = 0; i < 4; i++)
      beat(32'h100 + 32'(8*i), 1'b1, (i == 0) ? T_NONSEQ : T_SEQ, B_INCR4, 64'(i + 1), 8'hFF, i == 3, 0);
    idle();
    for (int i = 0; i < 4; i++)
      beat(32'h100 + 32'(8*i), 1'b0, (i == 0) ? T_NONSEQ : T_SEQ, B_INCR4, 64'd0, 8'h00, i == 3, 0);
    idle();
    check_drained("incr4");
  endtask

  task automatic test_incr8_stall();
    for (int i = 0; i < 8; i++)
      beat(32'h400 + 32'(8*i), 1'b1, (i == 0) ? T_NONSEQ : T_SEQ, B_INCR8,
           64'hA0A0_0000_0000_00A0 + 64'(i), 8'hFF, i == 7, (i == 4) ? 3 : 0);
    idle();
    for (int i = 0; i < 8; i++)
      beat(32'h400 + 32'(8*i), 1'b0, (i == 0) ? T_NONSEQ : T_SEQ, B_INCR8, 64'd0, 8'h00, i == 7, 0);
    idle();
    check_drained("incr8");
  endtask

  task automatic test_abort();
    beat(32'h200, 1'b1, T_NONSEQ, B_INCR4, 64'hCAFE_0000_0000_0200, 8'hFF, 1'b0, 0);
    beat(32'h208, 1'b1, T_SEQ,    B_INCR4, 64'hCAFE_0000_0000_0208, 8'hFF, 1'b0, 0);
    beat(32'h40,  1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    beat(32'h208, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    idle();
    check_drained("abort");
  endtask

  task automatic test_back_to_back();
    beat(32'h40, 1'b1, T_NONSEQ, B_SINGLE, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1, 0);
    beat(32'h40, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    beat(32'h60, 1'b1, T_NONSEQ, B_SINGLE, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 0);
    beat(32'h60, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    idle();
    check_drained("b2b");
  endtask

  task automatic test_out_of_range();
    beat(32'h0, 1'b1, T_NONSEQ, B_SINGLE, 64'h0BAD_F00D_0000_0001, 8'hFF, 1'b1, 0);
    idle();
    beat(32'(DEPTH * 8), 1'b1, T_NONSEQ, B_SINGLE, 64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b1, 0);
    idle();
    beat(32'h0, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    idle();
    check_drained("range");
  endtask

  task automatic test_reset_mid();
    beat(32'h48, 1'b1, T_NONSEQ, B_SINGLE, 64'h5555_6666_7777_8888, 8'hFF, 1'b1, 0);
    idle();
    HSEL = 1'b1; HADDR = 32'h48; HWRITE = 1'b1; HTRANS = T_NONSEQ; HBURST = B_SINGLE;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 64'hFFFF_FFFF_FFFF_FFFF; HWSTRB = 8'hFF;
    repeat (NSEQ_WAIT) @(posedge HCLK);
    #1;
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL mid_enter_data got rdy=%b want 1", HREADYOUT);
    end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'd0 || BurstDone !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out got rdy=%b resp=%b data=%h done=%b want 1 0 0 0",
               HREADYOUT, HRESP, HRDATA, BurstDone);
    end
    beat(32'h48, 1'b0, T_NONSEQ, B_SINGLE, 64'd0, 8'h00, 1'b1, 0);
    idle();
    check_drained("reset_mid");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
    test_reset();
    test_single();
    test_incr4_read();
    test_incr8_stall();
    test_abort();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    repeat (2) @(posedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
